// File: rtl/traffic_light_scheduler_pkg.sv
// Shared types for the traffic light scheduler: state encoding, lamp vector
// layout and the fixed phase order.
package traffic_light_pkg;

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        ALL_RED1 = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        ALL_RED2 = 3'd5,
        FLASH    = 3'd6
    } state_e;

    typedef struct packed {
        logic a_red;
        logic a_yel;
        logic a_grn;
        logic b_red;
        logic b_yel;
        logic b_grn;
    } lamps_t;

    localparam lamps_t LAMPS_OFF   = 6'b000_000;
    localparam lamps_t LAMPS_RED   = 6'b100_100;
    localparam lamps_t LAMPS_FLASH = 6'b010_010;

    function automatic state_e next_state(input state_e s);
        case (s)
            A_GREEN:  return A_YELLOW;
            A_YELLOW: return ALL_RED1;
            ALL_RED1: return B_GREEN;
            B_GREEN:  return B_YELLOW;
            B_YELLOW: return ALL_RED2;
            ALL_RED2: return A_GREEN;
            default:  return ALL_RED2;
        endcase
    endfunction

    function automatic lamps_t lamps_for(input state_e s);
        case (s)
            A_GREEN:  return 6'b001_100;
            A_YELLOW: return 6'b010_100;
            B_GREEN:  return 6'b100_001;
            B_YELLOW: return 6'b100_010;
            FLASH:    return LAMPS_FLASH;
            default:  return LAMPS_RED;
        endcase
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/traffic_light_scheduler_if.sv
// Board-side signal bundle of the scheduler: mode controls in, six lamps and
// debug state out. Build macro PED_REQ_EN adds the pedestrian button and the
// pending flag.
interface traffic_light_scheduler_if;
    logic       en;
    logic       flash_req;
    logic       a_red, a_yel, a_grn;
    logic       b_red, b_yel, b_grn;
    logic [2:0] state_o;
`ifdef PED_REQ_EN
    logic       ped_req;
    logic       ped_pend_o;

    modport master (
        input  en, flash_req, ped_req,
        output a_red, a_yel, a_grn, b_red, b_yel, b_grn, state_o, ped_pend_o
    );
    modport slave (
        output en, flash_req, ped_req,
        input  a_red, a_yel, a_grn, b_red, b_yel, b_grn, state_o, ped_pend_o
    );
`else
    modport master (
        input  en, flash_req,
        output a_red, a_yel, a_grn, b_red, b_yel, b_grn, state_o
    );
    modport slave (
        output en, flash_req,
        input  a_red, a_yel, a_grn, b_red, b_yel, b_grn, state_o
    );
`endif
endinterface

// File: rtl/traffic_light_scheduler_tick_gen.sv
// Free-running tick divider: one-clk tick every TICK_DIV clocks, restartable
// through a synchronous clear so a forced phase starts on a full tick period.
module tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] count_q, count_d;

    assign tick_o = (count_q == CW'(TICK_DIV - 1));

    // next count: clear wins, wrap on the tick
    always_comb begin
        count_d = count_q + 1'b1;
        if (clr_i || tick_o) count_d = '0;
    end

    // counter register
    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end
endmodule

// File: rtl/traffic_light_scheduler.sv
// Two-way intersection sequencer with flashing-yellow mode and lamp blanking.
// Build macro PED_REQ_EN enables the pedestrian request that shortens A green.
//
// state    | meaning
// A_GREEN  | road A green, B red
// A_YELLOW | road A yellow, B red
// ALL_RED1 | clearance before B
// B_GREEN  | road B green, A red
// B_YELLOW | road B yellow, A red
// ALL_RED2 | clearance before A; also reset/restart state
// FLASH    | both yellows blink on each tick, reds/greens dark
module traffic_light_scheduler #(
    parameter int TICK_DIV      = 25_000_000,
    parameter int GREEN_A       = 16,
    parameter int GREEN_B       = 10,
    parameter int YELLOW        = 4,
    parameter int ALL_RED       = 2,
    parameter int PED_GREEN_MIN = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    traffic_light_scheduler_if.master  bus
);
    import traffic_light_pkg::*;

    // timer must hold every duration and the pedestrian threshold
    localparam int MAX_DUR = max_of(max_of(GREEN_A, GREEN_B),
                                    max_of(max_of(YELLOW, ALL_RED), PED_GREEN_MIN));
    localparam int TW      = $clog2(MAX_DUR) + 1;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [TW-1:0]   last_cnt;
    lamps_t          lamps_q, lamps_d;
    logic            en_q;
    logic            tick;
    logic            tick_clr;
    logic            ped_cut;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    // terminal timer value of the current phase
    always_comb begin
        case (state_q)
            A_GREEN:            last_cnt = TW'(GREEN_A - 1);
            B_GREEN:            last_cnt = TW'(GREEN_B - 1);
            A_YELLOW, B_YELLOW: last_cnt = TW'(YELLOW - 1);
            default:            last_cnt = TW'(ALL_RED - 1);
        endcase
    end

`ifdef PED_REQ_EN
    logic ped_pend_q, ped_pend_d;

    assign ped_cut = (state_q == A_GREEN) && ped_pend_q &&
                     (timer_q >= TW'(PED_GREEN_MIN - 1));

    // sticky request, dropped once B actually gets its green
    always_comb begin
        ped_pend_d = ped_pend_q | bus.ped_req;
        if (state_d == B_GREEN && state_q != B_GREEN) ped_pend_d = 1'b0;
    end

    // pending-request register
    always_ff @(posedge clk) begin
        if (!rst_n) ped_pend_q <= 1'b0;
        else        ped_pend_q <= ped_pend_d;
    end

    assign bus.ped_pend_o = ped_pend_q;
`else
    assign ped_cut = 1'b0;
`endif

    // next state, timer and lamps; forced transitions restart the tick period.
    // The first enabled clock after blanking counts as a forced restart so the
    // clearance phase runs its full length.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        lamps_d  = lamps_q;
        tick_clr = 1'b0;
        if (!bus.en) begin
            state_d  = ALL_RED2;
            timer_d  = '0;
            lamps_d  = LAMPS_OFF;
            tick_clr = 1'b1;
        end else if (bus.flash_req) begin
            if (state_q != FLASH) begin
                state_d  = FLASH;
                timer_d  = '0;
                lamps_d  = LAMPS_FLASH;
                tick_clr = 1'b1;
            end else if (tick) begin
                lamps_d.a_yel = ~lamps_q.a_yel;
                lamps_d.b_yel = ~lamps_q.b_yel;
            end
        end else if (state_q == FLASH || !en_q) begin
            state_d  = ALL_RED2;
            timer_d  = '0;
            lamps_d  = LAMPS_RED;
            tick_clr = 1'b1;
        end else begin
            if (tick) begin
                if (timer_q == last_cnt || ped_cut) begin
                    state_d = next_state(state_q);
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            lamps_d = lamps_for(state_d);
        end
    end

    // state, timer and lamp registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ALL_RED2;
            timer_q <= '0;
            lamps_q <= LAMPS_RED;
            en_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            lamps_q <= lamps_d;
            en_q    <= bus.en;
        end
    end

    assign bus.a_red   = lamps_q.a_red;
    assign bus.a_yel   = lamps_q.a_yel;
    assign bus.a_grn   = lamps_q.a_grn;
    assign bus.b_red   = lamps_q.b_red;
    assign bus.b_yel   = lamps_q.b_yel;
    assign bus.b_grn   = lamps_q.b_grn;
    assign bus.state_o = state_q;
endmodule

// File: tb/tb_traffic_light_scheduler.sv
// Directed bench for traffic_light_scheduler with TICK_DIV=4 (one tick = 4 clk).
// Lamp vectors are {a_red,a_yel,a_grn,b_red,b_yel,b_grn}.
module tb_traffic_light_scheduler;

    localparam logic [5:0] RED = 6'b100_100;
    localparam logic [5:0] AG  = 6'b001_100;
    localparam logic [5:0] AY  = 6'b010_100;
    localparam logic [5:0] BG  = 6'b100_001;
    localparam logic [5:0] BY  = 6'b100_010;
    localparam logic [5:0] FY  = 6'b010_010;
    localparam logic [5:0] OFF = 6'b000_000;

    localparam logic [2:0] S_AG = 3'd0, S_AY = 3'd1, S_R1 = 3'd2, S_BG = 3'd3,
                           S_BY = 3'd4, S_R2 = 3'd5, S_FL = 3'd6;

    typedef struct {
        logic       en;
        logic       flash;
        int         n;
        logic [5:0] lamps;
        logic [2:0] st;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    traffic_light_scheduler_if tl_if();

    traffic_light_scheduler #(.TICK_DIV(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tl_if)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] lamps_now();
        return {tl_if.a_red, tl_if.a_yel, tl_if.a_grn,
                tl_if.b_red, tl_if.b_yel, tl_if.b_grn};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [5:0] exp_l, input logic [2:0] exp_s);
        checks++;
        if (lamps_now() !== exp_l || tl_if.state_o !== exp_s) begin
            errors++;
            $display("FAIL %s: lamps=%b state=%0d, expected lamps=%b state=%0d",
                     name, lamps_now(), tl_if.state_o, exp_l, exp_s);
        end
    endtask

`ifdef PED_REQ_EN
    task automatic check_pend(input string name, input logic exp);
        checks++;
        if (tl_if.ped_pend_o !== exp) begin
            errors++;
            $display("FAIL %s: ped_pend_o=%b expected %b", name, tl_if.ped_pend_o, exp);
        end
    endtask
`endif

    task automatic wait_state(input string name, input logic [2:0] s, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (tl_if.state_o === s) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: state=%0d never reached %0d within %0d clks",
                     name, tl_if.state_o, s, budget);
        end
    endtask

    function automatic void add(input logic en, input logic fl, input int n,
                                input logic [5:0] l, input logic [2:0] s, input string nm);
        vec_t v;
        v.en = en; v.flash = fl; v.n = n; v.lamps = l; v.st = s; v.name = nm;
        vecs.push_back(v);
    endfunction

    // safety invariant on every clock outside FLASH
    always @(negedge clk) begin
        if (rst_n && tl_if.state_o !== S_FL &&
            (tl_if.a_grn | tl_if.a_yel) && (tl_if.b_grn | tl_if.b_yel)) begin
            errors++;
            $display("FAIL safety: lamps=%b state=%0d both roads go", lamps_now(), tl_if.state_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // normal cycle
        add(1,0, 7,RED,S_R2,"ar2_hold");      add(1,0, 1,AG,S_AG,"a_grn_entry");
        add(1,0,63,AG,S_AG,"a_grn_last");     add(1,0, 1,AY,S_AY,"a_yel_entry");
        add(1,0,15,AY,S_AY,"a_yel_last");     add(1,0, 1,RED,S_R1,"ar1_entry");
        add(1,0, 7,RED,S_R1,"ar1_last");      add(1,0, 1,BG,S_BG,"b_grn_entry");
        add(1,0,39,BG,S_BG,"b_grn_last");     add(1,0, 1,BY,S_BY,"b_yel_entry");
        add(1,0,15,BY,S_BY,"b_yel_last");     add(1,0, 1,RED,S_R2,"ar2_entry");
        add(1,0, 7,RED,S_R2,"ar2_last");      add(1,0, 1,AG,S_AG,"cycle_repeat");
        // flash during B green
        add(1,0,63,AG,S_AG,"c2_a_grn");       add(1,0, 1,AY,S_AY,"c2_a_yel");
        add(1,0,15,AY,S_AY,"c2_a_yel_last");  add(1,0, 1,RED,S_R1,"c2_ar1");
        add(1,0, 7,RED,S_R1,"c2_ar1_last");   add(1,0, 1,BG,S_BG,"c2_b_grn");
        add(1,0, 5,BG,S_BG,"c2_b_grn_mid");   add(1,1, 1,FY,S_FL,"flash_entry");
        add(1,1, 3,FY,S_FL,"flash_on_hold");  add(1,1, 1,OFF,S_FL,"flash_toggle_off");
        add(1,1, 3,OFF,S_FL,"flash_off_hold"); add(1,1, 1,FY,S_FL,"flash_toggle_on");
        add(1,0, 1,RED,S_R2,"flash_exit");    add(1,0, 7,RED,S_R2,"flash_exit_red");
        add(1,0, 1,AG,S_AG,"flash_exit_agrn");
        // blanking during A yellow
        add(1,0,63,AG,S_AG,"c3_a_grn");       add(1,0, 1,AY,S_AY,"c3_a_yel");
        add(1,0, 3,AY,S_AY,"c3_a_yel_mid");   add(0,0, 1,OFF,S_R2,"en_off");
        add(0,0, 5,OFF,S_R2,"en_off_hold");   add(1,0, 1,RED,S_R2,"en_wake");
        add(1,0, 7,RED,S_R2,"en_wake_red");   add(1,0, 1,AG,S_AG,"en_wake_agrn");
        add(1,0,63,AG,S_AG,"en_wake_agrn_64"); add(1,0, 1,AY,S_AY,"en_wake_ayel");
        // flash request on the very tick that would end ALL_RED1
        add(1,0,15,AY,S_AY,"c4_a_yel_last");  add(1,0, 1,RED,S_R1,"c4_ar1");
        add(1,0, 7,RED,S_R1,"c4_ar1_last");   add(1,1, 1,FY,S_FL,"flash_beats_expiry");
        add(1,0, 1,RED,S_R2,"c4_flash_exit"); add(1,0, 7,RED,S_R2,"c4_red");
        add(1,0, 1,AG,S_AG,"c4_agrn");

        tl_if.en = 1'b1;
        tl_if.flash_req = 1'b0;
`ifdef PED_REQ_EN
        tl_if.ped_req = 1'b0;
`endif
        step(3);
        check("reset_state", RED, S_R2);
`ifdef PED_REQ_EN
        check_pend("reset_pend", 1'b0);
`endif
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            tl_if.en = vecs[i].en;
            tl_if.flash_req = vecs[i].flash;
            step(vecs[i].n);
            check(vecs[i].name, vecs[i].lamps, vecs[i].st);
        end

        // one-clock reset in the middle of B green
        wait_state("reach_b_grn", S_BG, 300);
        step(5);
        rst_n = 1'b0;
        step(1);
        check("reset_mid_bgrn", RED, S_R2);
        rst_n = 1'b1;
        step(7);
        check("reset_restart_red", RED, S_R2);
        step(1);
        check("reset_restart_agrn", AG, S_AG);

`ifdef PED_REQ_EN
        // press early in A green: cut after the sixth tick
        step(5);
        tl_if.ped_req = 1'b1;
        step(1);
        tl_if.ped_req = 1'b0;
        check_pend("ped_set", 1'b1);
        step(17);
        check("ped_agrn_hold", AG, S_AG);
        step(1);
        check("ped_cut_min", AY, S_AY);
        step(15);
        step(1);
        check("ped_ar1", RED, S_R1);
        step(7);
        check_pend("ped_kept", 1'b1);
        step(1);
        check("ped_bgrn", BG, S_BG);
        check_pend("ped_clear_bgrn", 1'b0);
        step(40);
        step(16);
        step(8);
        check("ped_agrn2", AG, S_AG);
        // press late in A green: cut at the next tick
        step(30);
        tl_if.ped_req = 1'b1;
        step(1);
        tl_if.ped_req = 1'b0;
        check("ped_late_hold", AG, S_AG);
        step(1);
        check("ped_late_cut", AY, S_AY);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
